mestre_memoria: RTL and testbench
=================================

MESTRE_MEMORIA -- requirements
Module: mestre_memoria

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: cmd_valid  input  1  command request.
REQ-004 SHALL: cmd_ready  output  1  high only in IDLE; the command is accepted on an edge where cmd_valid && cmd_ready.
REQ-005 SHALL: cmd_op  input  2  00 WRITE (single), 01 READ (burst), 10 FILL (burst write), 11 VERIFY (burst read-compare).
REQ-006 SHALL: cmd_addr  input  3  start address.
REQ-007 SHALL: cmd_len  input  3  beat count minus 1 (1..8 beats); ignored for WRITE (always 1 beat).
REQ-008 SHALL: cmd_data  input  8  write/fill data, or expected value for VERIFY.
REQ-009 SHALL: mem_endereco  output  3  memory address.
REQ-010 SHALL: mem_valor_escrita  output  8  memory write data.
REQ-011 SHALL: mem_escrita  output  1  memory write strobe.
REQ-012 SHALL: mem_leitura  output  1  memory read strobe.
REQ-013 SHALL: mem_valor_saida  input  8  registered memory read data, valid in the cycle after the mem_leitura cycle.
REQ-014 SHALL: rd_valid  output  1  one-cycle pulse per returned read beat.
REQ-015 SHALL: rd_data / rd_addr  output  8 / 3  returned data and its address.
REQ-016 SHALL: busy  output  1  high in every state except IDLE.
REQ-017 SHALL: done  output  1  one-cycle pulse at command completion.
REQ-018 SHALL: err_count  output  4  VERIFY mismatch count, 0..8.

Function
REQ-019 SHALL: FSM states are IDLE, WR, RD, WAIT, DONE; all outputs are driven from registers.
REQ-020 SHALL: on acceptance, latch op, addr, beat count (cmd_len+1, forced to 1 for WRITE) and data; cycle c1 is the first cycle after acceptance.
REQ-021 SHALL: WRITE/FILL: WR during c1..cn with mem_escrita=1, mem_valor_escrita=latched data and addresses a, a+1, ...; DONE in c(n+1); then IDLE.
REQ-022 SHALL: READ/VERIFY: RD during c1..cn with mem_leitura=1 and addresses a, a+1, ...; WAIT in c(n+1); DONE in c(n+2).
REQ-023 SHALL: sample mem_valor_saida at the end of c(i+1) for the beat issued in ci, so rd_valid, rd_data and rd_addr appear in c(i+2); the final rd_valid coincides with done.
REQ-024 SHALL: compute addresses modulo 8 (7 wraps to 0); an 8-beat burst touches each address exactly once.
REQ-025 SHALL: never assert mem_escrita and mem_leitura in the same cycle; both are 0 in IDLE, WAIT and DONE.
REQ-026 SHALL: VERIFY clears err_count on acceptance and increments it on each sampled beat that differs from the latched data; err_count holds otherwise, and READ also returns rd_valid beats without touching err_count.
REQ-027 SHALL: ignore cmd_valid while busy; the command inputs are not sampled then.
REQ-028 SHALL: let a command presented while done is high be accepted no earlier than the following IDLE cycle.
REQ-029 SHALL: hold mem_endereco and mem_valor_escrita at their last values when no strobe is active.

Reset
REQ-030 SHALL: reset_n=0 asynchronously forces IDLE and sets cmd_ready=1 (once reset_n is 1), busy=0, done=0, rd_valid=0, mem_escrita=0, mem_leitura=0, mem_endereco=0, mem_valor_escrita=0, rd_data=0, rd_addr=0 and err_count=0.
REQ-031 SHALL: reset mid-burst abandons the burst without a done pulse; memory contents already written are not this block's concern.

Structure
REQ-032 SHALL: package mestre_memoria_pkg holds the op encodings, the FSM state type, MEM_DEPTH=8, ADDR_W=3 and DATA_W=8.
REQ-033 SHALL: the single sub-module gerador_rajada holds the address register and beat counter (load, increment with wrap, last-beat flag).

Verification
REQ-034 SHALL: WRITE addr3 data 0x5A, then READ addr3 len0 -> mem_escrita in c1 at addr3; rd_valid in c3 with rd_data=0x5A and rd_addr=3; done in c3.
REQ-035 SHALL: FILL addr6 len7 data 0xFF -> mem_escrita in c1..c8 with addresses 6,7,0,1,2,3,4,5; done in c9; cmd_ready low c1..c9.
REQ-036 SHALL: READ addr5 len3 (memory preloaded with value = address) -> rd_valid in c3..c6 with data 5,6,7,0; done in c6.
REQ-037 SHALL: VERIFY addr0 len7 data 0x00 with two nonzero locations -> err_count=2 in c10 together with done.
REQ-038 SHALL: reset_n pulsed low during c3 of an 8-beat FILL -> strobes drop immediately, no done pulse, and cmd_ready=1 after release.
REQ-039 SHALL: cmd_valid held high with a new command while busy -> that command is not accepted until the IDLE cycle after done.

Source files
------------

// File: rtl/mestre_memoria_pkg.sv
// Shared definitions for the memory master: op encodings, FSM states,
// memory geometry and small helpers used by the top and its burst generator.
package mestre_memoria_pkg;

  localparam int MEM_DEPTH = 8;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;  // must hold a beat count of 1..MEM_DEPTH

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_FILL   = 2'b10,
    OP_VERIFY = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Number of beats a command performs; WRITE is always a single beat.
  function automatic logic [CNT_W-1:0] beat_count(input op_t op, input logic [ADDR_W-1:0] len);
    if (op == OP_WRITE) begin
      return 4'd1;
    end else begin
      return {1'b0, len} + 4'd1;
    end
  endfunction

  // WRITE and FILL drive the write strobe; READ and VERIFY drive the read strobe.
  function automatic logic is_write_op(input op_t op);
    return (op == OP_WRITE) || (op == OP_FILL);
  endfunction

endpackage

// File: rtl/mestre_memoria_rajada.sv
// Burst generator: holds the current memory address and the remaining beat
// count. Loaded on command acceptance, advanced once per beat, and it stops
// advancing on the last beat so the address holds once the strobe drops.
module gerador_rajada
  import mestre_memoria_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  beats,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [CNT_W-1:0] remaining_r;

  // Address/count register: load a new burst or advance one beat (address wraps mod 8).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr        <= 3'd0;
      remaining_r <= 4'd0;
    end else if (load) begin
      addr        <= start_addr;
      remaining_r <= beats;
    end else if (step) begin
      addr        <= addr + 3'd1;
      remaining_r <= remaining_r - 4'd1;
    end
  end

  assign last = (remaining_r == 4'd1);

endmodule

// File: rtl/mestre_memoria.sv
// Memory master: accepts single writes, burst reads, burst fills and burst
// read-compares, drives a registered-output memory port and returns read beats.
module mestre_memoria
  import mestre_memoria_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_valor_escrita,
  output logic              mem_escrita,
  output logic              mem_leitura,
  input  logic [DATA_W-1:0] mem_valor_saida,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [3:0]        err_count
);

  state_t            state_r;
  op_t               op_r;
  logic [DATA_W-1:0] data_r;
  logic              rd_pend_r;
  logic [ADDR_W-1:0] rd_pend_addr_r;
  logic              accept_s;
  logic              step_s;
  logic              last_s;
  logic [ADDR_W-1:0] burst_addr_s;

  // Acceptance handshake and per-beat advance of the burst generator.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    if ((state_r == S_IDLE) && cmd_valid && cmd_ready) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (((state_r == S_WR) || (state_r == S_RD)) && !last_s) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
  end

  gerador_rajada u_rajada (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (accept_s),
    .step       (step_s),
    .start_addr (cmd_addr),
    .beats      (beat_count(op_t'(cmd_op), cmd_len)),
    .addr       (burst_addr_s),
    .last       (last_s)
  );

  // The generator's address register is the memory address; it holds between bursts.
  assign mem_endereco = burst_addr_s;

  // Command FSM plus read-return pipeline: memory data of the beat issued in
  // one cycle is valid the next, and is registered onto rd_* the cycle after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= S_IDLE;
      op_r              <= OP_WRITE;
      data_r            <= 8'h00;
      cmd_ready         <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      mem_escrita       <= 1'b0;
      mem_leitura       <= 1'b0;
      mem_valor_escrita <= 8'h00;
      rd_pend_r         <= 1'b0;
      rd_pend_addr_r    <= 3'd0;
      rd_valid          <= 1'b0;
      rd_data           <= 8'h00;
      rd_addr           <= 3'd0;
      err_count         <= 4'd0;
    end else begin
      rd_pend_r      <= mem_leitura;
      rd_pend_addr_r <= mem_endereco;
      rd_valid       <= rd_pend_r;
      if (rd_pend_r) begin
        rd_data <= mem_valor_saida;
        rd_addr <= rd_pend_addr_r;
        if ((op_r == OP_VERIFY) && (mem_valor_saida != data_r)) begin
          err_count <= err_count + 4'd1;
        end
      end

      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r      <= op_t'(cmd_op);
            data_r    <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (op_t'(cmd_op) == OP_VERIFY) begin
              err_count <= 4'd0;
            end
            if (is_write_op(op_t'(cmd_op))) begin
              state_r           <= S_WR;
              mem_escrita       <= 1'b1;
              mem_valor_escrita <= cmd_data;
            end else begin
              state_r     <= S_RD;
              mem_leitura <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (last_s) begin
            state_r     <= S_DONE;
            mem_escrita <= 1'b0;
            done        <= 1'b1;
          end
        end
        S_RD: begin
          if (last_s) begin
            state_r     <= S_WAIT;
            mem_leitura <= 1'b0;
          end
        end
        S_WAIT: begin
          state_r <= S_DONE;
          done    <= 1'b1;
        end
        S_DONE: begin
          state_r   <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state_r     <= S_IDLE;
          cmd_ready   <= 1'b1;
          busy        <= 1'b0;
          done        <= 1'b0;
          mem_escrita <= 1'b0;
          mem_leitura <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mestre_memoria.sv
// Self-checking bench for mestre_memoria: a registered 8x8 memory model, a
// shadow of expected memory contents, a vector table and corner sequences.
module tb_mestre_memoria;

  localparam logic [1:0] C_WRITE  = 2'b00;
  localparam logic [1:0] C_READ   = 2'b01;
  localparam logic [1:0] C_FILL   = 2'b10;
  localparam logic [1:0] C_VERIFY = 2'b11;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_addr;
  logic [2:0] cmd_len;
  logic [7:0] cmd_data;
  logic [2:0] mem_endereco;
  logic [7:0] mem_valor_escrita;
  logic       mem_escrita;
  logic       mem_leitura;
  logic [7:0] mem_valor_saida;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] rd_addr;
  logic       busy;
  logic       done;
  logic [3:0] err_count;

  mestre_memoria dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .mem_endereco(mem_endereco), .mem_valor_escrita(mem_valor_escrita),
    .mem_escrita(mem_escrita), .mem_leitura(mem_leitura),
    .mem_valor_saida(mem_valor_saida), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_addr(rd_addr), .busy(busy), .done(done), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output memory: data of a read strobe appears the next cycle.
  logic [7:0] mem_model [8];
  always @(posedge clk) begin
    if (mem_escrita) mem_model[mem_endereco] <= mem_valor_escrita;
    if (mem_leitura) mem_valor_saida <= mem_model[mem_endereco];
  end

  logic [7:0] shadow [8];
  int errors = 0;
  int checks = 0;

  int done_cyc, n_done, n_wr, n_rd, n_rv, n_notready, n_busy, n_both, err_at_done;
  int wr_a [16];
  int wr_c [16];
  int rv_d [16];
  int rv_a [16];
  int rv_c [16];

  typedef struct {
    logic [1:0] op;
    logic [2:0] addr;
    logic [2:0] len;
    logic [7:0] data;
    int         exp_done;
    int         exp_err;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for cmd_ready, presents one command for one edge, then observes 14 cycles.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] l,
                         input logic [7:0] d);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    done_cyc = 0; n_done = 0; n_wr = 0; n_rd = 0; n_rv = 0;
    n_notready = 0; n_busy = 0; n_both = 0; err_at_done = -1;
    for (int k = 1; k <= 14; k++) begin
      if (mem_escrita) begin
        if (n_wr < 16) begin wr_a[n_wr] = int'(mem_endereco); wr_c[n_wr] = k; end
        n_wr++;
      end
      if (mem_leitura) n_rd++;
      if (rd_valid) begin
        if (n_rv < 16) begin rv_d[n_rv] = int'(rd_data); rv_a[n_rv] = int'(rd_addr); rv_c[n_rv] = k; end
        n_rv++;
      end
      if (!cmd_ready) n_notready++;
      if (busy) n_busy++;
      if (mem_escrita && mem_leitura) n_both++;
      if (done) begin
        if (n_done == 0) begin done_cyc = k; err_at_done = int'(err_count); end
        n_done++;
      end
      @(negedge clk);
    end
  endtask

  // Runs one command and compares every observation against hand/shadow expectations.
  task automatic do_vec(input string tag, input logic [1:0] op, input logic [2:0] a,
                        input logic [2:0] l, input logic [7:0] d, input int exp_done,
                        input int exp_err);
    int beats;
    run_cmd(op, a, l, d);
    beats = (op == C_WRITE) ? 1 : int'(l) + 1;
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " done_pulses"}, n_done, 1);
    chk({tag, " ready_low"}, n_notready, exp_done);
    chk({tag, " busy_cycles"}, n_busy, exp_done);
    chk({tag, " both_strobes"}, n_both, 0);
    chk({tag, " err_count"}, err_at_done, exp_err);
    if (op[0] == 1'b0) begin
      chk({tag, " write_beats"}, n_wr, beats);
      chk({tag, " rd_valid_beats"}, n_rv, 0);
      for (int i = 0; i < beats && i < n_wr && i < 16; i++) begin
        chk($sformatf("%s wr_addr%0d", tag, i), wr_a[i], (int'(a) + i) % 8);
        chk($sformatf("%s wr_cycle%0d", tag, i), wr_c[i], i + 1);
        shadow[(int'(a) + i) % 8] = d;
      end
    end else begin
      chk({tag, " read_beats"}, n_rd, beats);
      chk({tag, " rd_valid_beats"}, n_rv, beats);
      for (int i = 0; i < beats && i < n_rv && i < 16; i++) begin
        chk($sformatf("%s rd_addr%0d", tag, i), rv_a[i], (int'(a) + i) % 8);
        chk($sformatf("%s rd_data%0d", tag, i), rv_d[i], int'(shadow[(int'(a) + i) % 8]));
        chk($sformatf("%s rd_cycle%0d", tag, i), rv_c[i], i + 3);
      end
    end
  endtask

  initial begin
    int first_wr, wr_data_seen, wr_addr_seen, rv_cnt, dn_cyc, ready_c5;

    vecs[0]  = '{C_READ,   3'd5, 3'd3, 8'h00,  6, 0};
    vecs[1]  = '{C_WRITE,  3'd3, 3'd5, 8'h5A,  2, 0};
    vecs[2]  = '{C_READ,   3'd3, 3'd0, 8'h00,  3, 0};
    vecs[3]  = '{C_FILL,   3'd0, 3'd7, 8'h00,  9, 0};
    vecs[4]  = '{C_WRITE,  3'd2, 3'd0, 8'h11,  2, 0};
    vecs[5]  = '{C_WRITE,  3'd7, 3'd0, 8'h80,  2, 0};
    vecs[6]  = '{C_VERIFY, 3'd0, 3'd7, 8'h00, 10, 2};
    vecs[7]  = '{C_READ,   3'd6, 3'd2, 8'h00,  5, 2};
    vecs[8]  = '{C_FILL,   3'd6, 3'd7, 8'hFF,  9, 2};
    vecs[9]  = '{C_VERIFY, 3'd4, 3'd2, 8'hFF,  5, 0};
    vecs[10] = '{C_VERIFY, 3'd1, 3'd0, 8'h00,  3, 1};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 3'd0;
    cmd_len = 3'd0; cmd_data = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset cmd_ready", int'(cmd_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset strobes", int'({mem_escrita, mem_leitura, rd_valid}), 0);
    chk("reset mem_endereco", int'(mem_endereco), 0);
    chk("reset mem_valor_escrita", int'(mem_valor_escrita), 0);
    chk("reset rd_data", int'(rd_data), 0);
    chk("reset rd_addr", int'(rd_addr), 0);
    chk("reset err_count", int'(err_count), 0);

    // Preload memory with value = address through single writes.
    for (int i = 0; i < 8; i++) begin
      do_vec($sformatf("pre%0d", i), C_WRITE, 3'(i), 3'd0, 8'(i), 2, 0);
    end

    for (int v = 0; v < 11; v++) begin
      do_vec($sformatf("v%0d", v), vecs[v].op, vecs[v].addr, vecs[v].len,
             vecs[v].data, vecs[v].exp_done, vecs[v].exp_err);
    end
    chk("write data holds after read", int'(mem_valor_escrita), 8'hFF);

    // New command held on cmd_valid while busy: accepted only in the IDLE cycle after done.
    cmd_valid = 1'b1; cmd_op = C_READ; cmd_addr = 3'd0; cmd_len = 3'd1; cmd_data = 8'h00;
    @(negedge clk);
    cmd_op = C_FILL; cmd_addr = 3'd4; cmd_len = 3'd0; cmd_data = 8'h33;
    first_wr = 0; wr_data_seen = -1; wr_addr_seen = -1; rv_cnt = 0; dn_cyc = 0; ready_c5 = -1;
    for (int k = 1; k <= 10; k++) begin
      if (mem_escrita && first_wr == 0) begin
        first_wr = k; wr_data_seen = int'(mem_valor_escrita); wr_addr_seen = int'(mem_endereco);
        cmd_valid = 1'b0;
      end
      if (rd_valid) rv_cnt++;
      if (done && dn_cyc == 0) dn_cyc = k;
      if (k == 5) ready_c5 = int'(cmd_ready);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("held done_cycle", dn_cyc, 4);
    chk("held rd_valid beats", rv_cnt, 2);
    chk("held ready in idle gap", ready_c5, 1);
    chk("held first write cycle", first_wr, 6);
    chk("held write addr", wr_addr_seen, 4);
    chk("held write data", wr_data_seen, 8'h33);

    // Reset pulse during c3 of an 8-beat FILL abandons the burst.
    run_cmd_reset: begin
      cmd_valid = 1'b1; cmd_op = C_FILL; cmd_addr = 3'd0; cmd_len = 3'd7; cmd_data = 8'h77;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midreset write before", int'(mem_escrita), 1);
      reset_n = 1'b0;
      #1;
      chk("midreset strobes drop", int'({mem_escrita, mem_leitura}), 0);
      chk("midreset busy", int'(busy), 0);
      chk("midreset done", int'(done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      n_done = 0; n_wr = 0; n_notready = 0;
      for (int k = 0; k < 12; k++) begin
        if (done) n_done++;
        if (mem_escrita) n_wr++;
        if (!cmd_ready) n_notready++;
        @(negedge clk);
      end
      chk("midreset no done", n_done, 0);
      chk("midreset no writes", n_wr, 0);
      chk("midreset ready after", n_notready, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
